// File: rtl/bbox_crop_scaler_pkg.sv
// ---------------------------------------------------------------------------
// bbox_crop_scaler_pkg
// Shared types and helpers for the bounding-box crop/scale path. The
// bounding-box finder reads the same packed RGB frame, so it can reuse
// pixel_addr() and luma() from here.
//   state_t     FSM states of the crop scaler
//   pixel_addr  word address of one colour component (3 words per pixel,
//               row-major)
//   luma        (R + 2G + B) / 4 with truncation
// ---------------------------------------------------------------------------
package bbox_crop_scaler_pkg;

    localparam int COORD_W = 11;   // bbox coordinate width
    localparam int SPAN_W  = 12;   // box span width (holds up to 2048)

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RD_R,
        S_RD_G,
        S_RD_B,
        S_WR,
        S_DONE
    } state_t;

    function automatic logic [31:0] pixel_addr(input logic [COORD_W-1:0] sy,
                                               input logic [COORD_W-1:0] sx,
                                               input logic [1:0]         rgb,
                                               input int                 width);
        return 32'(sy) * 32'(width) * 32'd3 + 32'(sx) * 32'd3 + 32'(rgb);
    endfunction

    function automatic logic [7:0] luma(input logic [7:0] r,
                                        input logic [7:0] g,
                                        input logic [7:0] b);
        logic [9:0] sum;
        // The maximum sum is 1020, so ten bits are enough and cannot overflow.
        sum = 10'(r) + (10'(g) << 1) + 10'(b);
        return sum[9:2];
    endfunction

endpackage

// File: rtl/bbox_crop_scaler_axis.sv
// ---------------------------------------------------------------------------
// crop_axis_map
// Maps one axis of the output grid onto source coordinates. The box limits
// are captured on load. Before capture, max is clipped to SIZE-1. An empty
// box (min > clipped max) falls back to the whole axis.
//   clk, rst   clock and synchronous active-high reset
//   load       capture min_in/max_in
//   min_in     box lower bound
//   max_in     box upper bound
//   idx        output grid index along this axis
//   src        min' + ((idx * span) >> OUT_LOG2), never beyond max'
// ---------------------------------------------------------------------------
module crop_axis_map
    import bbox_crop_scaler_pkg::*;
#(
    parameter int SIZE     = 100,
    parameter int OUT_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [COORD_W-1:0] min_in,
    input  logic [COORD_W-1:0] max_in,
    input  logic [OUT_LOG2-1:0] idx,
    output logic [COORD_W-1:0] src
);

    localparam int PROD_W = SPAN_W + OUT_LOG2;

    logic [COORD_W-1:0] hi_clip;
    logic [COORD_W-1:0] lo;
    logic [COORD_W-1:0] hi;
    logic [COORD_W-1:0] lo_q;
    logic [SPAN_W-1:0]  span_q;
    logic [PROD_W-1:0]  prod;

    // NOTE: every always_comb output gets a default first, so no path can leave a latch.
    always_comb begin
        hi_clip = (max_in > COORD_W'(SIZE - 1)) ? COORD_W'(SIZE - 1) : max_in;
        lo      = min_in;
        hi      = hi_clip;
        if (min_in > hi_clip) begin
            lo = '0;
            hi = COORD_W'(SIZE - 1);
        end
    end

    // NOTE: use non-blocking assignments for state so that every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q   <= '0;
            span_q <= '0;
        end else if (load) begin
            lo_q   <= lo;
            span_q <= SPAN_W'(hi) - SPAN_W'(lo) + SPAN_W'(1);
        end
    end

    // idx < 2**OUT_LOG2, so (idx*span) >> OUT_LOG2 < span and src stays within max'.
    assign prod = PROD_W'(idx) * PROD_W'(span_q);
    assign src  = lo_q + COORD_W'(prod >> OUT_LOG2);

endmodule

// File: rtl/bbox_crop_scaler.sv
// ---------------------------------------------------------------------------
// bbox_crop_scaler
// Crops the RGB frame to a latched bounding box. It resamples the crop with
// nearest neighbour to an OUT_N x OUT_N grid and writes one 8-bit luma value
// per grid point.
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a crop (honoured in IDLE or DONE only)
//   done                     high in DONE; buffer contents valid
//   xMin/xMax/yMin/yMax      bounding box, latched in SETUP
//   rddata                   async image ROM data for addr (bits [7:0] used)
//   addr                     image word address, 0 outside the read states
//   wr_en/wr_addr/wr_data    feature-buffer write port, index = j*OUT_N + i
// ---------------------------------------------------------------------------
module bbox_crop_scaler
    import bbox_crop_scaler_pkg::*;
#(
    parameter int WIDTH    = 100,
    parameter int HEIGHT   = 100,
    parameter int OUT_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic [10:0]           xMin,
    input  logic [10:0]           xMax,
    input  logic [10:0]           yMin,
    input  logic [10:0]           yMax,
    input  logic [15:0]           rddata,
    output logic [31:0]           addr,
    output logic                  wr_en,
    output logic [2*OUT_LOG2-1:0] wr_addr,
    output logic [7:0]            wr_data
);

    state_t                state;
    logic [OUT_LOG2-1:0]   i;
    logic [OUT_LOG2-1:0]   j;
    logic [1:0]            rgb;
    logic [7:0]            r_q;
    logic [7:0]            g_q;
    logic [COORD_W-1:0]    sx;
    logic [COORD_W-1:0]    sy;
    logic                  unused_hi;

    assign unused_hi = ^rddata[15:8];

    crop_axis_map #(.SIZE(WIDTH), .OUT_LOG2(OUT_LOG2)) u_map_x (
        .clk    (clk),
        .rst    (rst),
        .load   (state == S_SETUP),
        .min_in (xMin),
        .max_in (xMax),
        .idx    (i),
        .src    (sx)
    );

    crop_axis_map #(.SIZE(HEIGHT), .OUT_LOG2(OUT_LOG2)) u_map_y (
        .clk    (clk),
        .rst    (rst),
        .load   (state == S_SETUP),
        .min_in (yMin),
        .max_in (yMax),
        .idx    (j),
        .src    (sy)
    );

    // The ROM answers in the same cycle, so addr is decoded directly from registered
    // state and counters instead of being registered one cycle ahead.
    always_comb begin
        addr = '0;
        if (state == S_RD_R || state == S_RD_G || state == S_RD_B)
            addr = pixel_addr(sy, sx, rgb, WIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            i       <= '0;
            j       <= '0;
            rgb     <= '0;
            r_q     <= '0;
            g_q     <= '0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_SETUP;
                        done  <= 1'b0;
                        i     <= '0;
                        j     <= '0;
                        rgb   <= '0;
                    end
                end
                S_SETUP: state <= S_RD_R;
                S_RD_R: begin
                    r_q   <= rddata[7:0];
                    rgb   <= 2'd1;
                    state <= S_RD_G;
                end
                S_RD_G: begin
                    g_q   <= rddata[7:0];
                    rgb   <= 2'd2;
                    state <= S_RD_B;
                end
                S_RD_B: begin
                    // Blue goes straight into the luma sum, so the strobe is high during WR.
                    rgb     <= 2'd0;
                    wr_en   <= 1'b1;
                    wr_addr <= {j, i};
                    wr_data <= luma(r_q, g_q, rddata[7:0]);
                    state   <= S_WR;
                end
                S_WR: begin
                    state <= S_RD_R;
                    if (i == '1) begin
                        i <= '0;
                        if (j == '1) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            j <= j + OUT_LOG2'(1);
                        end
                    end else begin
                        i <= i + OUT_LOG2'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_crop_scaler.sv
// ---------------------------------------------------------------------------
// tb_bbox_crop_scaler
// Scoreboard bench for bbox_crop_scaler. A behavioural image ROM drives
// rddata. Expected writes come from an independent model of the crop and
// resample. They are queued when a crop is started and popped when the DUT
// strobes wr_en.
// ---------------------------------------------------------------------------
module tb_bbox_crop_scaler;

    localparam int W   = 100;
    localparam int H   = 100;
    localparam int OL  = 4;
    localparam int N   = 1 << OL;
    localparam int LAT = 4 * N * N + 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic        done;
    logic [10:0] x_min, x_max, y_min, y_max;
    logic [15:0] rddata;
    logic [31:0] addr;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;

    logic [1:0]  mode;
    bit          mon_en;
    int          checks;
    int          errors;
    int          exp_first_addr;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    bbox_crop_scaler #(.WIDTH(W), .HEIGHT(H), .OUT_LOG2(OL)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .done    (done),
        .xMin    (x_min),
        .xMax    (x_max),
        .yMin    (y_min),
        .yMax    (y_max),
        .rddata  (rddata),
        .addr    (addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image ROM: mode 0 gives an address-dependent pattern, mode 1 gives constant R/G/B = 200/100/40, mode 2 gives all 255.
    function automatic logic [7:0] pix_byte(input int a, input logic [1:0] m);
        case (m)
            2'd1: begin
                case (a % 3)
                    0:       return 8'd200;
                    1:       return 8'd100;
                    default: return 8'd40;
                endcase
            end
            2'd2:    return 8'd255;
            default: return 8'(a * 37 + (a >> 8));
        endcase
    endfunction

    assign rddata = {8'hA5, pix_byte(int'(addr), mode)};

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (addr >= 32'(W * H * 3)) begin
                errors++;
                $display("FAIL addr_range: addr %0d exceeds %0d", addr, W * H * 3 - 1);
            end
            if (wr_en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: wr_addr %0d wr_data %0d with empty scoreboard", wr_addr, wr_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (wr_addr !== mon_e.a || wr_data !== mon_e.d) begin
                        errors++;
                        $display("FAIL write: got addr %0d data %0d, expected addr %0d data %0d",
                                 wr_addr, wr_data, mon_e.a, mon_e.d);
                    end
                end
            end
        end
    end

    // Independent crop/resample model; force_d >= 0 overrides the luma value.
    task automatic push_expected(input int xmn, input int xmx, input int ymn, input int ymx,
                                 input int force_d);
        int x0, x1, y0, y1, sx, sy, a, r, g, b, d;
        x1 = (xmx > W - 1) ? W - 1 : xmx;
        x0 = xmn;
        if (xmn > x1) begin x0 = 0; x1 = W - 1; end
        y1 = (ymx > H - 1) ? H - 1 : ymx;
        y0 = ymn;
        if (ymn > y1) begin y0 = 0; y1 = H - 1; end
        exp_first_addr = (y0 * W + x0) * 3;
        for (int jj = 0; jj < N; jj++) begin
            for (int ii = 0; ii < N; ii++) begin
                sx = x0 + (ii * (x1 - x0 + 1)) / N;
                sy = y0 + (jj * (y1 - y0 + 1)) / N;
                a  = (sy * W + sx) * 3;
                r  = int'(pix_byte(a, mode));
                g  = int'(pix_byte(a + 1, mode));
                b  = int'(pix_byte(a + 2, mode));
                d  = (force_d >= 0) ? force_d : (r + 2 * g + b) / 4;
                sb.push_back('{a: 8'(jj * N + ii), d: 8'(d)});
            end
        end
    endtask

    // Starts a crop, checks done timing and first address, and drains the scoreboard.
    task automatic run_crop(input int xmn, input int xmx, input int ymn, input int ymx,
                            input bit extra_starts);
        int m;
        @(negedge clk);
        x_min = 11'(xmn); x_max = 11'(xmx); y_min = 11'(ymn); y_max = 11'(ymx);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m = 0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_after_start: done %0b, expected 0", done);
        end
        while (done !== 1'b1 && m < 2 * LAT) begin
            @(negedge clk);
            m++;
            if (m == 1) begin
                checks++;
                if (addr !== 32'(exp_first_addr)) begin
                    errors++;
                    $display("FAIL first_addr: got %0d expected %0d", addr, exp_first_addr);
                end
                // Box is already latched; these values must not matter.
                x_min = 11'd3; x_max = 11'd5; y_min = 11'd7; y_max = 11'd9;
            end
            start = extra_starts && (m == 100 || m == 600);
        end
        start = 1'b0;
        checks++;
        if (m !== LAT) begin
            errors++;
            $display("FAIL done_latency: done after %0d edges, expected %0d", m, LAT);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL write_count: %0d expected writes never seen", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        if (wr_en !== 1'b0)  begin errors++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en); end
        if (wr_addr !== '0)  begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
        if (wr_data !== '0)  begin errors++; $display("FAIL reset_wr_data: got %0d expected 0", wr_data); end
        if (addr !== '0)     begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_box;
        mode = 2'd0;
        push_expected(10, 25, 40, 55, -1);
        run_crop(10, 25, 40, 55, 1'b0);
    endtask

    task automatic test_empty_box;
        mode = 2'd0;
        push_expected(99, 0, 99, 0, -1);
        run_crop(99, 0, 99, 0, 1'b0);
    endtask

    task automatic test_luma;
        mode = 2'd1;
        push_expected(30, 60, 20, 50, 110);
        run_crop(30, 60, 20, 50, 1'b0);
        mode = 2'd2;
        push_expected(0, 15, 0, 15, 255);
        run_crop(0, 15, 0, 15, 1'b0);
    endtask

    task automatic test_back_to_back;
        mode = 2'd0;
        push_expected(5, 70, 12, 33, -1);
        run_crop(5, 70, 12, 33, 1'b1);
    endtask

    task automatic test_mid_reset;
        int m;
        mode   = 2'd0;
        mon_en = 1'b0;
        @(negedge clk);
        x_min = 11'd0; x_max = 11'd15; y_min = 11'd0; y_max = 11'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m = 0;
        while (m < 150) begin
            @(negedge clk);
            m++;
        end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL mid_run_done: got %0b expected 0", done); end
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL abort_wr_en: got %0b expected 0", wr_en); end
        if (done !== 1'b0)  begin errors++; $display("FAIL abort_done: got %0b expected 0", done); end
        if (addr !== '0)    begin errors++; $display("FAIL abort_addr: got %0d expected 0", addr); end
        if (wr_addr !== '0) begin errors++; $display("FAIL abort_wr_addr: got %0d expected 0", wr_addr); end
        rst = 1'b0;
        sb.delete();
        mon_en = 1'b1;
        push_expected(20, 35, 60, 75, -1);
        run_crop(20, 35, 60, 75, 1'b0);
    endtask

    task automatic test_clip;
        mode = 2'd0;
        push_expected(90, 150, 80, 300, -1);
        run_crop(90, 150, 80, 300, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mode   = 2'd0;
        mon_en = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        x_min  = '0; x_max = '0; y_min = '0; y_max = '0;
        exp_first_addr = 0;

        test_reset;
        mon_en = 1'b1;
        test_box;
        test_empty_box;
        test_luma;
        test_back_to_back;
        test_mid_reset;
        test_clip;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
